// File: rtl/serial_bit_feeder.sv
// rtl/serial_bit_feeder.sv - parallel-to-serial bit feeder for the sequence detector input
//
// Accepts a NUM_BITS word over a valid/ready handshake and shifts it out one
// bit at a time on serial_out. Each bit is held for DIV cycles, and bit_strobe
// marks the first cycle of each bit. A word accepted on the final cycle of the
// previous word follows with no idle gap.
//
// Optional feature macro: SERIAL_BIT_FEEDER_PARITY_EN
//   defined   - an even-parity bit (XOR of the word) follows the data bits
//   undefined - exactly NUM_BITS bits per word
//
// Ports:
//   clk        in   system clock, rising edge
//   n_rst      in   asynchronous active-low reset
//   load_data  in   word to transmit (sampled only at transfer)
//   load_valid in   load_data valid
//   load_ready out  block can accept a word this cycle
//   serial_out out  registered serial bit
//   bit_strobe out  one-cycle pulse on the first cycle of each bit
//   busy       out  a word (or parity bit) is in flight

module serial_bit_feeder #(
    parameter int   NUM_BITS  = 8,
    parameter int   DIV       = 1,
    parameter int   MSB_FIRST = 1,
    parameter logic IDLE_VAL  = 1'b0
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [NUM_BITS-1:0] load_data,
    input  logic                load_valid,
    output logic                load_ready,
    output logic                serial_out,
    output logic                bit_strobe,
    output logic                busy
);

`ifdef SERIAL_BIT_FEEDER_PARITY_EN
    localparam int LAST_BIT = NUM_BITS;
`else
    localparam int LAST_BIT = NUM_BITS - 1;
`endif
    localparam int CNT_W = $clog2(NUM_BITS + 1);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_BIT);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state_q, state_d;
    logic [NUM_BITS-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic                out_q, out_d;
    logic                strobe_q, strobe_d;
    logic                busy_q, busy_d;
    logic                last_cycle;
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
    logic                parity_q, parity_d;
`endif

    function automatic logic head(input logic [NUM_BITS-1:0] w);
        return (MSB_FIRST != 0) ? w[NUM_BITS-1] : w[0];
    endfunction

    function automatic logic [NUM_BITS-1:0] advance(input logic [NUM_BITS-1:0] w);
        return (MSB_FIRST != 0) ? {w[NUM_BITS-2:0], 1'b0} : {1'b0, w[NUM_BITS-1:1]};
    endfunction

    // Final cycle of the final bit on the line: the only SHIFT cycle that can
    // accept the next word, which is what makes back-to-back words gapless.
    assign last_cycle = (state_q == SHIFT) && (div_cnt_q == DIV_LAST) && (bit_cnt_q == CNT_LAST);
    assign load_ready = (state_q == IDLE) || last_cycle;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        out_d     = out_q;
        strobe_d  = 1'b0;
        busy_d    = busy_q;
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
        parity_d  = parity_q;
`endif
        if (load_valid && load_ready) begin
            // First bit goes straight to the output register; the shift
            // register keeps only the bits still to be sent.
            state_d   = SHIFT;
            out_d     = head(load_data);
            shreg_d   = advance(load_data);
            bit_cnt_d = '0;
            div_cnt_d = '0;
            strobe_d  = 1'b1;
            busy_d    = 1'b1;
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
            parity_d  = ^load_data;
`endif
        end else if (state_q == SHIFT) begin
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = '0;
                if (bit_cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    out_d   = IDLE_VAL;
                    busy_d  = 1'b0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    strobe_d  = 1'b1;
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
                    if (bit_cnt_q == CNT_W'(NUM_BITS - 1)) begin
                        out_d = parity_q;
                    end else begin
                        out_d   = head(shreg_q);
                        shreg_d = advance(shreg_q);
                    end
`else
                    out_d   = head(shreg_q);
                    shreg_d = advance(shreg_q);
`endif
                end
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            out_q     <= IDLE_VAL;
            strobe_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            out_q     <= out_d;
            strobe_q  <= strobe_d;
            busy_q    <= busy_d;
        end
    end

`ifdef SERIAL_BIT_FEEDER_PARITY_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign serial_out = out_q;
    assign bit_strobe = strobe_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb/tb_serial_bit_feeder.sv - self-checking bench for serial_bit_feeder

module tb_serial_bit_feeder;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [7:0] d1, d3;
    logic       v1, v3;
    logic       r1, o1, s1, b1;
    logic       r3, o3, s3, b3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_bit_feeder #(.NUM_BITS(8), .DIV(1), .MSB_FIRST(1), .IDLE_VAL(1'b0)) dut (
        .clk(clk), .n_rst(n_rst), .load_data(d1), .load_valid(v1),
        .load_ready(r1), .serial_out(o1), .bit_strobe(s1), .busy(b1)
    );

    serial_bit_feeder #(.NUM_BITS(8), .DIV(3), .MSB_FIRST(0), .IDLE_VAL(1'b0)) dut3 (
        .clk(clk), .n_rst(n_rst), .load_data(d3), .load_valid(v3),
        .load_ready(r3), .serial_out(o3), .bit_strobe(s3), .busy(b3)
    );

    typedef struct {
        bit       v;
        bit [7:0] d;
        bit       o;
        bit       s;
        bit       b;
        bit       r;
        string    tag;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic add(input bit v, input bit [7:0] d, input bit o, input bit s,
                       input bit b, input bit r, input string tag);
        vec_t e;
        e.v = v; e.d = d; e.o = o; e.s = s; e.b = b; e.r = r; e.tag = tag;
        vq.push_back(e);
    endtask

    task automatic chk1(input string tag, input bit o, input bit s, input bit b, input bit r);
        chk({tag, ".out"},   o1, o);
        chk({tag, ".strobe"}, s1, s);
        chk({tag, ".busy"},  b1, b);
        chk({tag, ".ready"}, r1, r);
    endtask

    initial begin
        bit [7:0]  sw;
        bit [15:0] bb;
        bit [7:0]  pw;
        bit        exp_o;
        int        pulses;
        int        n3;

        // ---------------- vector table ----------------
        // Single word 8'hDB, MSB first: 1,1,0,1,1,0,1,1
        sw = 8'b1101_1011;
        add(1, 8'hDB, 0, 0, 0, 1, "single_load");
        for (int k = 0; k < 8; k++) begin
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
            add(0, 8'h00, sw[7-k], 1, 1, 0, $sformatf("single_bit%0d", k));
`else
            add(0, 8'h00, sw[7-k], 1, 1, (k == 7), $sformatf("single_bit%0d", k));
`endif
        end
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
        add(0, 8'h00, 0, 1, 1, 1, "single_parity");
`endif
        add(0, 8'h00, 0, 0, 0, 1, "single_end0");
        add(0, 8'h00, 0, 0, 0, 1, "single_end1");

        // Back-to-back F0 then 0D; 0D is presented while F0 is still shifting
        bb = 16'b1111_0000_0000_1101;
        add(1, 8'hF0, 0, 0, 0, 1, "b2b_load");
        for (int k = 0; k < 8; k++) begin
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
            add(1, 8'h0D, bb[15-k], 1, 1, 0, $sformatf("b2b_w0_bit%0d", k));
`else
            add(1, 8'h0D, bb[15-k], 1, 1, (k == 7), $sformatf("b2b_w0_bit%0d", k));
`endif
        end
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
        add(1, 8'h0D, 0, 1, 1, 1, "b2b_w0_parity");
`endif
        for (int k = 0; k < 8; k++) begin
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
            add(0, 8'h00, bb[7-k], 1, 1, 0, $sformatf("b2b_w1_bit%0d", k));
`else
            add(0, 8'h00, bb[7-k], 1, 1, (k == 7), $sformatf("b2b_w1_bit%0d", k));
`endif
        end
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
        add(0, 8'h00, 1, 1, 1, 1, "b2b_w1_parity");
`endif
        add(0, 8'h00, 0, 0, 0, 1, "b2b_end");

`ifdef SERIAL_BIT_FEEDER_PARITY_EN
        // 8'b0000_0111 then parity 1; ready only on the 9th bit
        pw = 8'b0000_0111;
        add(1, 8'h07, 0, 0, 0, 1, "par_load");
        for (int k = 0; k < 8; k++)
            add(0, 8'h00, pw[7-k], 1, 1, 0, $sformatf("par_bit%0d", k));
        add(0, 8'h00, 1, 1, 1, 1, "par_parity");
        add(0, 8'h00, 0, 0, 0, 1, "par_end");
`else
        pw = 8'h00;
`endif

        // ---------------- reset then idle ----------------
        n_rst = 1'b0; v1 = 1'b0; v3 = 1'b0; d1 = 8'h00; d3 = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        chk1("rst_hold", 0, 0, 0, 1);
        n_rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            chk1($sformatf("idle%0d", c), 0, 0, 0, 1);
            chk($sformatf("idle%0d.busy3", c), b3, 1'b0);
            chk($sformatf("idle%0d.ready3", c), r3, 1'b1);
        end

        // ---------------- table replay ----------------
        foreach (vq[i]) begin
            @(negedge clk);
            v1 = vq[i].v;
            d1 = vq[i].d;
            #1;
            chk1(vq[i].tag, vq[i].o, vq[i].s, vq[i].b, vq[i].r);
        end
        v1 = 1'b0;

        // ---------------- DIV=3, LSB first, 8'h01 ----------------
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
        n3 = 27;
`else
        n3 = 24;
`endif
        pulses = 0;
        @(negedge clk);
        v3 = 1'b1; d3 = 8'h01;
        #1;
        chk("div3_load.ready", r3, 1'b1);
        @(negedge clk);
        v3 = 1'b0; d3 = 8'hAA;
        for (int c = 0; c < n3; c++) begin
            #1;
            exp_o = (c < 3);
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
            if (c >= 24) exp_o = 1'b1;
`endif
            chk($sformatf("div3_c%0d.out", c), o3, exp_o);
            chk($sformatf("div3_c%0d.strobe", c), s3, (c % 3) == 0);
            chk($sformatf("div3_c%0d.busy", c), b3, 1'b1);
            chk($sformatf("div3_c%0d.ready", c), r3, c == n3 - 1);
            if (s3 === 1'b1) pulses++;
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if (pulses != n3 / 3) begin
            n_bad++;
            $display("FAIL div3_pulses: got %0d expected %0d", pulses, n3 / 3);
        end
        chk("div3_end.out", o3, 1'b0);
        chk("div3_end.busy", b3, 1'b0);

        // ---------------- reset mid-word ----------------
        @(negedge clk);
        v1 = 1'b1; d1 = 8'hFF;
        @(negedge clk);
        v1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("midrst_pre.out", o1, 1'b1);
        chk("midrst_pre.busy", b1, 1'b1);
        #1;
        n_rst = 1'b0;
        #1;
        chk1("midrst_async", 0, 0, 0, 1);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        #1;
        chk1("midrst_after", 0, 0, 0, 1);
        @(negedge clk);
        #1;
        chk1("midrst_after2", 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_bit_feeder.md
Name: serial_bit_feeder

Overview:
- Parallel-to-serial stage directly upstream of the Moore sequence detector; drives the detector's single-bit `i` input.
- Accepts a NUM_BITS word over a valid/ready handshake.
- Shifts the word out one bit at a time, each bit held for DIV clock cycles, with a strobe marking each new bit.
- Supports back-to-back words with no idle gap, so detector patterns spanning word boundaries are preserved.

Parameters:
- NUM_BITS, 8, data word width (>=2).
- DIV, 1, clock cycles each bit is held on serial_out (>=1).
- MSB_FIRST, 1, 1 = shift MSB first; 0 = LSB first.
- IDLE_VAL, 0, serial_out level while no word is being sent.

Ports:
- clk  input  1  system clock, rising-edge.
- n_rst  input  1  asynchronous active-low reset.
- load_data  input  NUM_BITS  word to transmit.
- load_valid  input  1  load_data valid.
- load_ready  output  1  block can accept a word this cycle.
- serial_out  output  1  serial bit to detector input i.
- bit_strobe  output  1  one-cycle pulse on the first cycle of each new bit.
- busy  output  1  a word (or parity bit) is in flight.

Behaviour:
- Reset (n_rst=0, asynchronous, overrides all):
  - state=IDLE; shift register, bit counter and divider cleared.
  - serial_out=IDLE_VAL, bit_strobe=0, busy=0, load_ready=1.
- Reset mid-word aborts the word; there is no resume.
- States: IDLE, SHIFT.
- Handshake:
  - Transfer occurs at a rising edge with load_valid=1 and load_ready=1.
  - load_ready=1 in IDLE.
  - load_ready=1 in SHIFT only on the final cycle of the final bit: divider==DIV-1 and bit count==NUM_BITS-1, or the parity bit when PARITY_EN is defined. Otherwise 0.
  - load_data is sampled only at transfer; later changes are ignored.
- IDLE -> SHIFT on transfer. The first bit appears on serial_out the cycle after transfer, with bit_strobe=1 and busy=1 that cycle. Latency is 1 cycle.
- In SHIFT:
  - Divider counts 0..DIV-1. At DIV-1 it wraps to 0 and the next bit is presented with bit_strobe=1.
  - serial_out is registered and holds the current bit for exactly DIV cycles.
- End of word:
  - Transfer on the final cycle: the next word's first bit follows immediately (strobe continues), state stays SHIFT, busy stays 1.
  - No transfer on the final cycle: -> IDLE next cycle, serial_out=IDLE_VAL, busy=0.
- DIV=1: bit_strobe is high every SHIFT cycle. Divider width is max(1,$clog2(DIV)); bit counter width is $clog2(NUM_BITS+1).
- load_valid asserted while load_ready=0 is ignored. No data is lost because the upstream must hold it.
- Outputs are glitch-free registers; no combinational path from load_valid to serial_out. load_ready may be combinational from state and counters only.

Optional Feature:
- Macro: SERIAL_BIT_FEEDER_PARITY_EN
- Defined:
  - After the NUM_BITS data bits, one extra even-parity bit (XOR of the word) is sent, held DIV cycles with bit_strobe.
  - Word length on the line becomes NUM_BITS+1.
  - load_ready asserts on the final cycle of the parity bit.
- Undefined: no parity bit; exactly NUM_BITS bits per word.

Test Plan:
- Reset then idle: n_rst=0 for 2 cycles, release, no load_valid for 5 cycles -> serial_out=0, busy=0, load_ready=1, bit_strobe=0 throughout.
- Single word, DIV=1, MSB_FIRST=1:
  - Stimulus: load 8'b1101_1011, load_valid for 1 cycle.
  - serial_out on the 8 cycles after transfer = 1,1,0,1,1,0,1,1.
  - bit_strobe=1 on all 8 cycles.
  - Then serial_out=0, busy=0.
- Back-to-back, DIV=1:
  - Stimulus: hold load_valid with 8'hF0 then 8'h0D.
  - load_ready high only on cycle 8 of the first word.
  - 16 consecutive bits 1111_0000_0000_1101 with no gap; busy never drops.
- Divider, DIV=3, MSB_FIRST=0:
  - Stimulus: load 8'h01.
  - serial_out=1 for 3 cycles, then 0 for 21 cycles.
  - bit_strobe pulses every 3rd cycle, 8 pulses total.
- Reset mid-word, DIV=1: load 8'hFF, assert n_rst=0 asynchronously after 3 bits -> serial_out=0, busy=0 immediately, without waiting for a clock edge; load_ready=1 after release.
- Parity, DIV=1, macro defined: load 8'b0000_0111 -> 9 bits 0000_0111 then parity 1; load_ready high on the 9th bit only.
